ysyx_22040750_ifu_pc: RTL and testbench

PC register and instruction-fetch front end. It consumes the next-PC (dnpc) stream produced by the next-PC generator over a valid/ready handshake, fetches from instruction memory, and presents {pc, snpc, inst} to the IF/ID stage under valid/ready. At most one fetch is in flight. A fetch issues only once the dnpc for the previous instruction has been accepted.

---
 rtl/ysyx_22040750_ifu_pc_if.sv | 75 +++++++
 rtl/ysyx_22040750_ifu_pc.sv | 136 +++++++++++++
 tb/tb_ysyx_22040750_ifu_pc.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040750_ifu_pc_if.sv
// ---------------------------------------------------------------------------
// ysyx_22040750_ifu_pc_if
//   Bundle of every handshake/bus signal around the IFU PC front end.
//   Signal names keep the IFU's point of view: I_* flows into the IFU and
//   O_* flows out of it.
//
//   Groups:
//     dnpc   : I_dnpc_valid / O_dnpc_ready / I_dnpc   next PC from the generator
//     flush  : I_flush                                 kill buffer and in-flight fetch
//     imem   : O_imem_req_valid / I_imem_req_ready / O_imem_addr
//              I_imem_rsp_valid / I_imem_rsp_data     request and response
//     IF/ID  : O_IF_ID_valid / I_IF_ID_ready / O_IF_ID_pc / O_IF_ID_snpc /
//              O_IF_ID_inst                            decode-side buffer
//
//   Modports:
//     master : the IFU itself
//     slave  : the surroundings (next-PC generator, imem, decode)
// ---------------------------------------------------------------------------
interface ysyx_22040750_ifu_pc_if #(
  parameter int W = 32
) ();

  logic         I_dnpc_valid;
  logic         O_dnpc_ready;
  logic [W-1:0] I_dnpc;

  logic         I_flush;

  logic         O_imem_req_valid;
  logic         I_imem_req_ready;
  logic [W-1:0] O_imem_addr;
  logic         I_imem_rsp_valid;
  logic [W-1:0] I_imem_rsp_data;

  logic         O_IF_ID_valid;
  logic         I_IF_ID_ready;
  logic [W-1:0] O_IF_ID_pc;
  logic [W-1:0] O_IF_ID_snpc;
  logic [W-1:0] O_IF_ID_inst;

  modport master (
    input  I_dnpc_valid,
    output O_dnpc_ready,
    input  I_dnpc,
    input  I_flush,
    output O_imem_req_valid,
    input  I_imem_req_ready,
    output O_imem_addr,
    input  I_imem_rsp_valid,
    input  I_imem_rsp_data,
    output O_IF_ID_valid,
    input  I_IF_ID_ready,
    output O_IF_ID_pc,
    output O_IF_ID_snpc,
    output O_IF_ID_inst
  );

  modport slave (
    output I_dnpc_valid,
    input  O_dnpc_ready,
    output I_dnpc,
    output I_flush,
    input  O_imem_req_valid,
    output I_imem_req_ready,
    input  O_imem_addr,
    output I_imem_rsp_valid,
    output I_imem_rsp_data,
    input  O_IF_ID_valid,
    output I_IF_ID_ready,
    input  O_IF_ID_pc,
    input  O_IF_ID_snpc,
    input  O_IF_ID_inst
  );

endinterface

// File: rtl/ysyx_22040750_ifu_pc.sv
// ---------------------------------------------------------------------------
// ysyx_22040750_ifu_pc
//   PC register and instruction-fetch front end. Holds pc_reg, issues one
//   imem fetch at a time from it, parks the returned instruction in the
//   IF/ID buffer as {pc, snpc, inst}, then waits for the next PC (dnpc)
//   before fetching again.
//
//   Ports:
//     I_clk  : clock, rising edge
//     I_rst  : synchronous, active-high reset
//     bus    : ysyx_22040750_ifu_pc_if.master (dnpc, flush, imem, IF/ID)
//
//   Parameters:
//     RESET_PC : address of the first fetch after reset
//     INST_W   : instruction and address width
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   BOOT   | one idle cycle out of reset, nothing asserted
//   REQ    | fetch request for pc_reg offered when the buffer is free
//   WAIT   | request accepted, waiting for the imem response
//   NEXT   | instruction handled, waiting for dnpc to update pc_reg
// ---------------------------------------------------------------------------
module ysyx_22040750_ifu_pc #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          INST_W   = 32
) (
  input logic                     I_clk,
  input logic                     I_rst,
  ysyx_22040750_ifu_pc_if.master  bus
);

  localparam logic [INST_W-1:0] INST_BYTES = INST_W'(4);
  localparam logic [INST_W-1:0] PC_INIT    = INST_W'(RESET_PC);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_NEXT = 2'd3
  } state_t;

  state_t              state;
  logic [INST_W-1:0]   pc_reg;
  logic                drop;

  logic                if_id_valid;
  logic [INST_W-1:0]   if_id_pc;
  logic [INST_W-1:0]   if_id_snpc;
  logic [INST_W-1:0]   if_id_inst;

  logic                buf_free;
  logic                req_valid;
  logic                req_fire;
  logic                dnpc_ready;
  logic                dnpc_fire;
  logic                rsp_in_wait;
  logic                load;

  // The buffer only loads in WAIT, so once buf_free is seen high in REQ it
  // stays high until the request is accepted; req_valid therefore never
  // drops before its handshake.
  assign buf_free    = !if_id_valid || bus.I_IF_ID_ready;
  assign req_valid   = (state == S_REQ) && buf_free;
  assign req_fire    = req_valid && bus.I_imem_req_ready;
  assign dnpc_ready  = (state == S_NEXT);
  assign dnpc_fire   = dnpc_ready && bus.I_dnpc_valid;
  assign rsp_in_wait = (state == S_WAIT) && bus.I_imem_rsp_valid;
  // A flush in the response cycle counts as a drop of that response.
  assign load        = rsp_in_wait && !drop && !bus.I_flush;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state       <= S_BOOT;
      pc_reg      <= PC_INIT;
      drop        <= 1'b0;
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_snpc  <= '0;
      if_id_inst  <= '0;
    end else begin
      case (state)
        S_BOOT: begin
          state <= S_REQ;
        end
        S_REQ: begin
          // Flushing before or during the request poisons its response.
          if (bus.I_flush) begin
            drop <= 1'b1;
          end
          if (req_fire) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.I_imem_rsp_valid) begin
            drop  <= 1'b0;
            state <= S_NEXT;
          end else if (bus.I_flush) begin
            drop <= 1'b1;
          end
        end
        S_NEXT: begin
          // The redirect target after a flush also arrives here as dnpc.
          if (dnpc_fire) begin
            pc_reg <= bus.I_dnpc;
            state  <= S_REQ;
          end
        end
        default: begin
          state <= S_BOOT;
        end
      endcase

      if (bus.I_flush) begin
        if_id_valid <= 1'b0;
      end else if (load) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= pc_reg;
        if_id_snpc  <= pc_reg + INST_BYTES;
        if_id_inst  <= bus.I_imem_rsp_data;
      end else if (bus.I_IF_ID_ready) begin
        if_id_valid <= 1'b0;
      end
    end
  end

  assign bus.O_dnpc_ready     = dnpc_ready;
  assign bus.O_imem_req_valid = req_valid;
  assign bus.O_imem_addr      = pc_reg;
  assign bus.O_IF_ID_valid    = if_id_valid;
  assign bus.O_IF_ID_pc       = if_id_pc;
  assign bus.O_IF_ID_snpc     = if_id_snpc;
  assign bus.O_IF_ID_inst     = if_id_inst;

endmodule

// File: tb/tb_ysyx_22040750_ifu_pc.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22040750_ifu_pc
//   Directed stimulus drives the dnpc, imem and decode sides; every response
//   that should reach IF/ID pushes its hand-written {pc, snpc, inst} into a
//   queue, and an independent monitor pops and compares on each IF/ID
//   handshake. Outputs are sampled on the falling edge, inputs change 1 time
//   unit after it, and the monitor looks 2 time units after the falling edge.
// ---------------------------------------------------------------------------
module tb_ysyx_22040750_ifu_pc;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] snpc;
    logic [31:0] inst;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ysyx_22040750_ifu_pc_if #(.W(32)) bus ();

  ysyx_22040750_ifu_pc #(
    .RESET_PC (RESET_PC),
    .INST_W   (32)
  ) dut (
    .I_clk (clk),
    .I_rst (rst),
    .bus   (bus.master)
  );

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec   = 0;
  int   n_bad   = 0;
  int   exp_acc = 0;
  int   act_acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor and imem-accept counter
  always @(negedge clk) begin
    #2;
    if (rst === 1'b0) begin
      if (bus.O_imem_req_valid && bus.I_imem_req_ready) act_acc++;
      if (bus.O_IF_ID_valid && bus.I_IF_ID_ready) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL if_id_unexpected: got pc %h inst %h, expected no output",
                   bus.O_IF_ID_pc, bus.O_IF_ID_inst);
        end else begin
          mon_e = sb_q.pop_front();
          chk("if_id_pc",   bus.O_IF_ID_pc,   mon_e.pc);
          chk("if_id_snpc", bus.O_IF_ID_snpc, mon_e.snpc);
          chk("if_id_inst", bus.O_IF_ID_inst, mon_e.inst);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_req(input logic [31:0] exp_addr);
    int n = 0;
    @(negedge clk);
    while (!bus.O_imem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_valid", 32'(bus.O_imem_req_valid), 32'd1);
    chk("req_addr", bus.O_imem_addr, exp_addr);
    #1;
  endtask

  task automatic accept(input logic [31:0] exp_addr, input int stall);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_req_valid", 32'(bus.O_imem_req_valid), 32'd1);
      chk("stall_req_addr", bus.O_imem_addr, exp_addr);
      #1;
    end
    bus.I_imem_req_ready = 1'b1;
    exp_acc++;
    @(negedge clk);
    chk("req_after_accept", 32'(bus.O_imem_req_valid), 32'd0);
    #1;
    bus.I_imem_req_ready = 1'b0;
  endtask

  task automatic respond(input int idle, input logic [31:0] data, input logic [31:0] pc,
                         input logic [31:0] snpc, input bit push);
    repeat (idle) begin
      @(negedge clk);
      #1;
    end
    bus.I_imem_rsp_valid = 1'b1;
    bus.I_imem_rsp_data  = data;
    if (push) sb_q.push_back({pc, snpc, data});
    @(negedge clk);
    #1;
    bus.I_imem_rsp_valid = 1'b0;
  endtask

  task automatic give_dnpc(input logic [31:0] d, input int hold);
    int n = 0;
    @(negedge clk);
    while (!bus.O_dnpc_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("dnpc_ready", 32'(bus.O_dnpc_ready), 32'd1);
    repeat (hold) begin
      #1;
      @(negedge clk);
      chk("dnpc_ready_hold", 32'(bus.O_dnpc_ready), 32'd1);
    end
    #1;
    bus.I_dnpc_valid = 1'b1;
    bus.I_dnpc       = d;
    @(negedge clk);
    #1;
    bus.I_dnpc_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_if_id_valid"}, 32'(bus.O_IF_ID_valid), 32'd0);
    chk({tag, "_req_valid"},   32'(bus.O_imem_req_valid), 32'd0);
    chk({tag, "_dnpc_ready"},  32'(bus.O_dnpc_ready), 32'd0);
    chk({tag, "_if_id_pc"},    bus.O_IF_ID_pc, 32'h0);
    chk({tag, "_if_id_snpc"},  bus.O_IF_ID_snpc, 32'h0);
    chk({tag, "_if_id_inst"},  bus.O_IF_ID_inst, 32'h0);
    chk({tag, "_imem_addr"},   bus.O_imem_addr, 32'h8000_0000);
  endtask

  initial begin
    rst                  = 1'b1;
    bus.I_dnpc_valid     = 1'b0;
    bus.I_dnpc           = 32'h0;
    bus.I_flush          = 1'b0;
    bus.I_imem_req_ready = 1'b0;
    bus.I_imem_rsp_valid = 1'b0;
    bus.I_imem_rsp_data  = 32'h0;
    bus.I_IF_ID_ready    = 1'b1;

    // Reset and boot
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    #1 rst = 1'b0;
    @(negedge clk);
    chk("boot_req_valid", 32'(bus.O_imem_req_valid), 32'd1);
    chk("boot_req_addr", bus.O_imem_addr, 32'h8000_0000);
    chk("boot_dnpc_ready", 32'(bus.O_dnpc_ready), 32'd0);
    #1;
    accept(32'h8000_0000, 0);
    respond(0, 32'h0000_0413, 32'h8000_0000, 32'h8000_0004, 1'b1);
    give_dnpc(32'h8000_0004, 2);
    wait_req(32'h8000_0004);
    accept(32'h8000_0004, 0);

    // Back-pressure from decode
    bus.I_IF_ID_ready = 1'b0;
    respond(0, 32'h0010_0093, 32'h8000_0004, 32'h8000_0008, 1'b1);
    give_dnpc(32'h8000_0010, 0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_req_valid", 32'(bus.O_imem_req_valid), 32'd0);
      chk("bp_req_addr", bus.O_imem_addr, 32'h8000_0010);
      chk("bp_buf_valid", 32'(bus.O_IF_ID_valid), 32'd1);
      chk("bp_buf_pc", bus.O_IF_ID_pc, 32'h8000_0004);
    end
    #1 bus.I_IF_ID_ready = 1'b1;
    #1 chk("bp_req_rise", 32'(bus.O_imem_req_valid), 32'd1);

    // Imem stall for 5 cycles
    accept(32'h8000_0010, 5);
    respond(0, 32'h0020_0113, 32'h8000_0010, 32'h8000_0014, 1'b1);

    // Flush in WAIT, response three cycles later
    give_dnpc(32'h8000_0020, 0);
    wait_req(32'h8000_0020);
    accept(32'h8000_0020, 0);
    bus.I_flush = 1'b1;
    @(negedge clk);
    chk("flw_buf_valid", 32'(bus.O_IF_ID_valid), 32'd0);
    #1 bus.I_flush = 1'b0;
    respond(2, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("flw_drop_buf_valid", 32'(bus.O_IF_ID_valid), 32'd0);
    chk("flw_dnpc_ready", 32'(bus.O_dnpc_ready), 32'd1);
    #1;
    give_dnpc(32'h8000_0100, 0);
    wait_req(32'h8000_0100);
    accept(32'h8000_0100, 0);
    respond(0, 32'h0030_0193, 32'h8000_0100, 32'h8000_0104, 1'b1);

    // Flush and response in the same WAIT cycle
    give_dnpc(32'h8000_0200, 0);
    wait_req(32'h8000_0200);
    accept(32'h8000_0200, 0);
    bus.I_flush          = 1'b1;
    bus.I_imem_rsp_valid = 1'b1;
    bus.I_imem_rsp_data  = 32'hCAFE_F00D;
    @(negedge clk);
    chk("fsr_buf_valid", 32'(bus.O_IF_ID_valid), 32'd0);
    chk("fsr_dnpc_ready", 32'(bus.O_dnpc_ready), 32'd1);
    #1;
    bus.I_flush          = 1'b0;
    bus.I_imem_rsp_valid = 1'b0;
    give_dnpc(32'h8000_0300, 0);
    wait_req(32'h8000_0300);
    accept(32'h8000_0300, 0);
    respond(1, 32'h0040_0213, 32'h8000_0300, 32'h8000_0304, 1'b1);

    // Flush while in REQ poisons the upcoming response
    give_dnpc(32'h8000_0400, 0);
    bus.I_flush = 1'b1;
    @(negedge clk);
    #1 bus.I_flush = 1'b0;
    wait_req(32'h8000_0400);
    accept(32'h8000_0400, 0);
    respond(0, 32'h1111_1111, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("flr_buf_valid", 32'(bus.O_IF_ID_valid), 32'd0);
    chk("flr_dnpc_ready", 32'(bus.O_dnpc_ready), 32'd1);
    #1;

    // snpc wraps past the top of the address space
    give_dnpc(32'hFFFF_FFFC, 0);
    wait_req(32'hFFFF_FFFC);
    accept(32'hFFFF_FFFC, 0);
    respond(0, 32'h0050_0293, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1);

    // Reset while a fetch is in flight; a late response is ignored
    give_dnpc(32'h8000_0500, 0);
    wait_req(32'h8000_0500);
    accept(32'h8000_0500, 0);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    #1;
    rst                  = 1'b0;
    bus.I_imem_rsp_valid = 1'b1;
    bus.I_imem_rsp_data  = 32'h2222_2222;
    @(negedge clk);
    chk("midrst_req_valid", 32'(bus.O_imem_req_valid), 32'd1);
    chk("midrst_req_addr", bus.O_imem_addr, 32'h8000_0000);
    chk("midrst_buf_valid", 32'(bus.O_IF_ID_valid), 32'd0);
    #1 bus.I_imem_rsp_valid = 1'b0;
    accept(32'h8000_0000, 0);
    respond(0, 32'h0060_0313, 32'h8000_0000, 32'h8000_0004, 1'b1);

    repeat (3) @(negedge clk);
    #3;
    chk("sb_left", 32'(sb_q.size()), 32'd0);
    chk("req_accepts", 32'(act_acc), 32'(exp_acc));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
